painterengine_gpu_blend_source: RTL and testbench

- Pixel-processing stage directly upstream of the GPU DMA writer.
- Pops ARGB8888 pixels from a source stream (normally the DMA reader), alpha-blends each one with a constant colour, and presents the results to the writer's data/valid/next port.
- One blend job covers a programmed pixel count and signals done or error when it finishes.
- The output port uses the writer's handshake: a word is consumed in the cycle where next is high while valid is high.

---
 rtl/painterengine_gpu_pkg.sv | 29 ++
 rtl/painterengine_gpu_blend_channel.sv | 43 ++++
 rtl/painterengine_gpu_blend_source.sv | 178 +++++++++++++++++
 tb/tb_painterengine_gpu_blend_source.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/painterengine_gpu_pkg.sv
// Shared encodings for the painterengine GPU blend path: FSM states, error codes,
// ARGB8888 channel offsets and the alpha expansion used by the blend arithmetic.
package painterengine_gpu_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DONE  = 2'd2,
      ST_ERROR = 2'd3
   } state_t;

   typedef enum logic [1:0] {
      ERR_OK       = 2'd0,
      ERR_ZERO_LEN = 2'd1,
      ERR_TIMEOUT  = 2'd2
   } err_t;

   localparam int CH_W       = 8;
   localparam int ARGB_A_LSB = 24;
   localparam int ARGB_R_LSB = 16;
   localparam int ARGB_G_LSB = 8;
   localparam int ARGB_B_LSB = 0;

   // Maps 0..255 onto 0..256 so that 0xFF selects the colour exactly.
   function automatic logic [CH_W:0] alpha_expand(input logic [CH_W-1:0] a);
      return {1'b0, a} + {{CH_W{1'b0}}, a[CH_W-1]};
   endfunction

endpackage

// File: rtl/painterengine_gpu_blend_channel.sv
// One 8-bit colour channel of the blend: S1 holds the two weighted products,
// S2 holds the shifted sum that drives the output word.
module painterengine_gpu_blend_channel
   import painterengine_gpu_pkg::*;
(
   input  logic              i_wire_clock,
   input  logic              i_wire_reset,
   input  logic              en1,
   input  logic              en2,
   input  logic [CH_W-1:0]   src_c,
   input  logic [CH_W-1:0]   col_c,
   input  logic [CH_W:0]     ae,
   output logic [CH_W-1:0]   out_c
);

   localparam int PW = 2 * CH_W + 1;

   logic [CH_W:0]  inv_ae;
   logic [PW-1:0]  prod_src_q;
   logic [PW-1:0]  prod_col_q;
   logic [PW-1:0]  sum;

   assign inv_ae = 9'd256 - ae;
   // Weights add up to 256, so the sum tops out at 255*256 and the shifted value fits 8 bits.
   assign sum    = prod_src_q + prod_col_q;

   always_ff @(posedge i_wire_clock) begin
      if (i_wire_reset) begin
         prod_src_q <= '0;
         prod_col_q <= '0;
         out_c      <= '0;
      end else begin
         if (en1) begin
            prod_src_q <= {{(PW-CH_W){1'b0}}, src_c} * {{(PW-CH_W-1){1'b0}}, inv_ae};
            prod_col_q <= {{(PW-CH_W){1'b0}}, col_c} * {{(PW-CH_W-1){1'b0}}, ae};
         end
         if (en2) begin
            out_c <= CH_W'(sum >> CH_W);
         end
      end
   end

endmodule

// File: rtl/painterengine_gpu_blend_source.sv
// Blend stage ahead of the GPU DMA writer: pops source pixels, blends them with a
// constant colour through a two-stage pipeline and hands them to the writer.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | no job since reset; waiting for start
// ST_RUN   | popping, blending and emitting pixels; timeout armed
// ST_DONE  | all programmed pixels consumed; waits for the next start
// ST_ERROR | zero length or timeout; error_type says which
module painterengine_gpu_blend_source
   import painterengine_gpu_pkg::*;
#(
   parameter int PARAM_TIMEOUT = 65535
) (
   input  logic        i_wire_clock,
   input  logic        i_wire_reset,
   input  logic        i_wire_start,
   input  logic [31:0] i_wire_color,
   input  logic [31:0] i_wire_length,
   output logic        o_wire_done,
   output logic        o_wire_error,
   output logic [1:0]  o_wire_error_type,
   input  logic [31:0] i_wire_src_data,
   input  logic        i_wire_src_valid,
   output logic        o_wire_src_next,
   output logic [31:0] o_wire_data,
   output logic        o_wire_data_valid,
   input  logic        i_wire_data_next
);

   localparam logic [31:0] TMO_LOAD = 32'(PARAM_TIMEOUT);

   state_t      state_q, state_d;
   err_t        err_q, err_d;
   logic        load;
   logic [31:0] color_q;
   logic [31:0] length_q;
   logic [31:0] in_count_q;
   logic [31:0] out_count_q;
   logic [31:0] tmo_q;
   logic        tmo_tc;
   logic        pop;
   logic        consume;
   logic        v1_q, v2_q;
   logic [7:0]  a1_q, a2_q;
   logic        en1, en2;
   logic [8:0]  ae;
   logic [7:0]  r_c, g_c, b_c;

   assign en2     = !v2_q || i_wire_data_next;
   assign en1     = !v1_q || en2;
   assign pop     = i_wire_src_valid && (state_q == ST_RUN) && (in_count_q < length_q) && en1;
   assign consume = v2_q && i_wire_data_next;
   // Idle timer is a down-counter reloaded on activity; terminal count means the limit was reached.
   assign tmo_tc  = (tmo_q == 32'd0);
   assign ae      = alpha_expand(color_q[ARGB_A_LSB +: CH_W]);

   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      load    = 1'b0;
      case (state_q)
         ST_IDLE, ST_DONE, ST_ERROR: begin
            if (i_wire_start) begin
               if (i_wire_length == 32'd0) begin
                  state_d = ST_ERROR;
                  err_d   = ERR_ZERO_LEN;
               end else begin
                  load    = 1'b1;
                  state_d = ST_RUN;
                  err_d   = ERR_OK;
               end
            end
         end
         ST_RUN: begin
            if (consume && (out_count_q + 32'd1 == length_q)) begin
               state_d = ST_DONE;
            end else if (tmo_tc) begin
               state_d = ST_ERROR;
               err_d   = ERR_TIMEOUT;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_wire_clock) begin
      if (i_wire_reset) begin
         state_q     <= ST_IDLE;
         err_q       <= ERR_OK;
         color_q     <= '0;
         length_q    <= '0;
         in_count_q  <= '0;
         out_count_q <= '0;
         tmo_q       <= TMO_LOAD;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         if (load) begin
            color_q     <= i_wire_color;
            length_q    <= i_wire_length;
            in_count_q  <= '0;
            out_count_q <= '0;
            tmo_q       <= TMO_LOAD;
         end else begin
            if (pop)     in_count_q  <= in_count_q + 32'd1;
            if (consume) out_count_q <= out_count_q + 32'd1;
            if (state_q == ST_RUN) begin
               if (pop || consume) tmo_q <= TMO_LOAD;
               else if (!tmo_tc)   tmo_q <= tmo_q - 32'd1;
            end
         end
      end
   end

   // A new job starts from an empty pipeline, even if a timed-out job left words behind.
   always_ff @(posedge i_wire_clock) begin
      if (i_wire_reset) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
         a1_q <= '0;
         a2_q <= '0;
      end else if (load) begin
         v1_q <= 1'b0;
         v2_q <= 1'b0;
      end else begin
         if (en1) begin
            v1_q <= pop;
            a1_q <= i_wire_src_data[ARGB_A_LSB +: CH_W];
         end
         if (en2) begin
            v2_q <= v1_q;
            a2_q <= a1_q;
         end
      end
   end

   painterengine_gpu_blend_channel u_ch_r (
      .i_wire_clock (i_wire_clock),
      .i_wire_reset (i_wire_reset),
      .en1          (en1),
      .en2          (en2),
      .src_c        (i_wire_src_data[ARGB_R_LSB +: CH_W]),
      .col_c        (color_q[ARGB_R_LSB +: CH_W]),
      .ae           (ae),
      .out_c        (r_c)
   );

   painterengine_gpu_blend_channel u_ch_g (
      .i_wire_clock (i_wire_clock),
      .i_wire_reset (i_wire_reset),
      .en1          (en1),
      .en2          (en2),
      .src_c        (i_wire_src_data[ARGB_G_LSB +: CH_W]),
      .col_c        (color_q[ARGB_G_LSB +: CH_W]),
      .ae           (ae),
      .out_c        (g_c)
   );

   painterengine_gpu_blend_channel u_ch_b (
      .i_wire_clock (i_wire_clock),
      .i_wire_reset (i_wire_reset),
      .en1          (en1),
      .en2          (en2),
      .src_c        (i_wire_src_data[ARGB_B_LSB +: CH_W]),
      .col_c        (color_q[ARGB_B_LSB +: CH_W]),
      .ae           (ae),
      .out_c        (b_c)
   );

   assign o_wire_src_next   = pop;
   assign o_wire_data       = {a2_q, r_c, g_c, b_c};
   assign o_wire_data_valid = v2_q;
   assign o_wire_done       = (state_q == ST_DONE);
   assign o_wire_error      = (state_q == ST_ERROR);
   assign o_wire_error_type = err_q;

endmodule

// File: tb/tb_painterengine_gpu_blend_source.sv
// Self-checking bench for painterengine_gpu_blend_source: table of single-pixel
// blends plus multi-pixel, stall, zero-length, timeout and reset sequences.
module tb_painterengine_gpu_blend_source;

   localparam int P = 20;

   logic        clk = 1'b0;
   logic        rst, start;
   logic [31:0] color, length, src_data, data;
   logic        src_valid, src_next, data_valid, data_next;
   logic        done, error;
   logic [1:0]  error_type;

   always #5 clk = ~clk;

   painterengine_gpu_blend_source #(.PARAM_TIMEOUT(P)) dut (
      .i_wire_clock      (clk),
      .i_wire_reset      (rst),
      .i_wire_start      (start),
      .i_wire_color      (color),
      .i_wire_length     (length),
      .o_wire_done       (done),
      .o_wire_error      (error),
      .o_wire_error_type (error_type),
      .i_wire_src_data   (src_data),
      .i_wire_src_valid  (src_valid),
      .o_wire_src_next   (src_next),
      .o_wire_data       (data),
      .o_wire_data_valid (data_valid),
      .i_wire_data_next  (data_next)
   );

   typedef struct {
      logic [31:0] col;
      logic [31:0] src;
      logic [31:0] exp;
   } vec_t;

   int          n_cmp = 0, n_err = 0, cyc = 0;
   logic [31:0] sb_q[$];
   logic [31:0] src_pix[16];
   int          src_idx, src_cnt;
   logic        src_en;
   int          stall_at, stall_left;
   logic        sink_block;
   logic [31:0] job_color, last_out, prev_data;
   logic        prev_hold;
   int          n_pop, n_cons, pop_first, val_first, cons_first, cons_last, done_cyc, max_fly;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] blend_model(input logic [31:0] col, input logic [31:0] src);
      int a, ae, s, k;
      logic [31:0] r;
      a  = int'(col[31:24]);
      ae = a + ((a >= 128) ? 1 : 0);
      r  = '0;
      r[31:24] = src[31:24];
      for (int c = 0; c < 3; c++) begin
         s = int'((src >> (8 * c)) & 32'hFF);
         k = int'((col >> (8 * c)) & 32'hFF);
         r[8*c +: 8] = 8'((s * (256 - ae) + k * ae) >> 8);
      end
      return r;
   endfunction

   task automatic drive_src();
      src_valid = src_en && (src_idx < src_cnt);
      src_data  = (src_idx < 16) ? src_pix[src_idx] : 32'h0;
   endtask

   task automatic tick();
      logic popped;
      @(negedge clk);
      popped = (src_next === 1'b1);
      if (popped) begin
         sb_q.push_back(blend_model(job_color, src_data));
         n_pop++;
         if (pop_first < 0) pop_first = cyc;
      end
      if (data_valid && val_first < 0) val_first = cyc;
      if (prev_hold) begin
         check("hold_valid", {31'd0, data_valid}, 32'd1);
         check("hold_data", data, prev_data);
      end
      if (data_valid && data_next) begin
         if (sb_q.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL sb_extra: got %h expected no output", data);
         end else begin
            check("sb_data", data, sb_q.pop_front());
         end
         n_cons++;
         last_out = data;
         if (cons_first < 0) cons_first = cyc;
         cons_last = cyc;
      end
      prev_hold = data_valid && !data_next;
      prev_data = data;
      if (n_pop - n_cons > max_fly) max_fly = n_pop - n_cons;
      @(posedge clk); #1;
      cyc++;
      if (done && done_cyc < 0) done_cyc = cyc;
      if (popped) src_idx++;
      drive_src();
      if (stall_at >= 0 && n_cons == stall_at) begin
         stall_left = 10;
         stall_at   = -1;
      end
      if (sink_block) data_next = 1'b0;
      else if (stall_left > 0) begin
         stall_left--;
         data_next = 1'b0;
      end else data_next = 1'b1;
   endtask

   task automatic setup_src(input logic en, input int cnt);
      src_en = en; src_idx = 0; src_cnt = cnt;
      drive_src();
   endtask

   task automatic start_job(input logic [31:0] col, input logic [31:0] len);
      sb_q.delete();
      n_pop = 0; n_cons = 0; pop_first = -1; val_first = -1;
      cons_first = -1; cons_last = -1; done_cyc = -1; max_fly = 0;
      color = col; length = len; job_color = col; start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_end(input int budget, output int k);
      k = 0;
      while (!done && !error && k < budget) begin
         tick();
         k++;
      end
   endtask

   vec_t tab[6];
   int   k;

   initial begin
      tab[0] = '{32'h80FF0000, 32'hFF0000FF, 32'hFF80007E};
      tab[1] = '{32'hFF00FF00, 32'h12345678, 32'h1200FF00};
      tab[2] = '{32'h00ABCDEF, 32'h11223344, 32'h11223344};
      tab[3] = '{32'h7F000000, 32'h40FFFFFF, 32'h40808080};
      tab[4] = '{32'h80FFFFFF, 32'h00FFFFFF, 32'h00FFFFFF};
      tab[5] = '{32'hFF123456, 32'hAB000000, 32'hAB123456};

      rst = 1'b1; start = 1'b0; color = '0; length = '0;
      src_en = 1'b0; src_idx = 0; src_cnt = 0; src_valid = 1'b0; src_data = '0;
      data_next = 1'b1; sink_block = 1'b0; stall_at = -1; stall_left = 0; prev_hold = 1'b0;
      job_color = '0; last_out = '0; prev_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_valid", {31'd0, data_valid}, 32'd0);
      check("rst_data", data, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_error", {31'd0, error}, 32'd0);
      check("rst_type", {30'd0, error_type}, 32'd0);
      check("rst_next", {31'd0, src_next}, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 6; i++) begin
         src_pix[0] = tab[i].src;
         setup_src(1'b1, 1);
         start_job(tab[i].col, 32'd1);
         wait_end(30, k);
         check($sformatf("tab%0d_done", i), {31'd0, done}, 32'd1);
         check($sformatf("tab%0d_out", i), last_out, tab[i].exp);
         if (i == 0) begin
            check("t1_latency", 32'(val_first - pop_first), 32'd2);
            check("t1_done_cyc", 32'(done_cyc - cons_last), 32'd1);
         end
      end

      for (int i = 0; i < 6; i++) src_pix[i] = 32'h12345678;
      setup_src(1'b1, 6);
      start_job(32'hFF00FF00, 32'd4);
      wait_end(50, k);
      repeat (3) tick();
      check("t2_done", {31'd0, done}, 32'd1);
      check("t2_pops", 32'(n_pop), 32'd4);
      check("t2_cons", 32'(n_cons), 32'd4);
      check("t2_b2b", 32'(cons_last - cons_first), 32'd3);
      check("t2_out", last_out, 32'h1200FF00);

      src_pix[0] = 32'h11223344; src_pix[1] = 32'hA5A55A5A; src_pix[2] = 32'h00FF7F80;
      setup_src(1'b1, 3);
      start_job(32'h00ABCDEF, 32'd3);
      wait_end(50, k);
      check("t3_done", {31'd0, done}, 32'd1);
      check("t3_cons", 32'(n_cons), 32'd3);
      check("t3_out", last_out, 32'h00FF7F80);

      for (int i = 0; i < 12; i++)
         src_pix[i] = {8'(i * 16 + 1), 8'(i * 3), 8'(255 - i * 7), 8'(i * 29)};
      setup_src(1'b1, 12);
      stall_at = 3;
      start_job(32'h5A3C7896, 32'd8);
      wait_end(200, k);
      check("t4_done", {31'd0, done}, 32'd1);
      check("t4_cons", 32'(n_cons), 32'd8);
      check("t4_pops", 32'(n_pop), 32'd8);
      check("t4_inflight_le2", {31'd0, max_fly <= 2}, 32'd1);
      check("t4_sb_empty", 32'(sb_q.size()), 32'd0);

      setup_src(1'b0, 0);
      start_job(32'h12345678, 32'd0);
      check("t5_error", {31'd0, error}, 32'd1);
      check("t5_type", {30'd0, error_type}, 32'd1);
      src_pix[0] = 32'h01020304; src_pix[1] = 32'hF0E0D0C0;
      setup_src(1'b1, 2);
      start_job(32'hFF00FF00, 32'd2);
      check("t5_run_err", {31'd0, error}, 32'd0);
      check("t5_run_type", {30'd0, error_type}, 32'd0);
      check("t5_run_done", {31'd0, done}, 32'd0);
      wait_end(50, k);
      check("t5_done", {31'd0, done}, 32'd1);
      check("t5_cons", 32'(n_cons), 32'd2);

      setup_src(1'b0, 0);
      start_job(32'h80808080, 32'd5);
      wait_end(100, k);
      check("t6_error", {31'd0, error}, 32'd1);
      check("t6_type", {30'd0, error_type}, 32'd2);
      check("t6_cycles", 32'(k), 32'(P + 1));
      check("t6_pops", 32'(n_pop), 32'd0);

      for (int i = 0; i < 5; i++) src_pix[i] = 32'hC0000000 | 32'(i);
      setup_src(1'b1, 5);
      sink_block = 1'b1;
      data_next  = 1'b0;
      start_job(32'h80FF0000, 32'd5);
      repeat (4) tick();
      check("t7_valid_pre", {31'd0, data_valid}, 32'd1);
      rst = 1'b1;
      @(posedge clk); #1;
      check("t7_valid", {31'd0, data_valid}, 32'd0);
      check("t7_data", data, 32'd0);
      check("t7_next", {31'd0, src_next}, 32'd0);
      check("t7_done", {31'd0, done}, 32'd0);
      check("t7_error", {31'd0, error}, 32'd0);
      check("t7_type", {30'd0, error_type}, 32'd0);
      rst = 1'b0;
      sink_block = 1'b0; data_next = 1'b1; prev_hold = 1'b0;
      sb_q.delete();
      n_cons = 0;
      setup_src(1'b0, 0);
      repeat (3) tick();
      check("t7_no_output", 32'(n_cons), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL global_timeout: got no end expected summary");
      $fatal(1, "bench time limit");
   end

endmodule
